// File: rtl/prbs5_checker_if.sv
// Link-test bus between a PRBS5 stream source and the prbs5_checker.
// The checker side exposes its FSM state for debug visibility.
interface prbs5_checker_if #(
   parameter int CNT_W = 16
);
   // bit_valid qualifies bit_in for one cycle; there is no ready, the checker accepts every valid bit.
   logic             clr;
   logic             bit_valid;
   logic             bit_in;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic [1:0]       state;

   modport master (
      output clr, bit_valid, bit_in,
      input  locked, err_pulse, err_count, bit_count, state
   );

   modport slave (
      input  clr, bit_valid, bit_in,
      output locked, err_pulse, err_count, bit_count, state
   );
endinterface

// File: rtl/prbs5_checker.sv
// Self-synchronising checker for the b[n] = b[n-5] ^ b[n-2] pattern stream.
// Seeds from the line, verifies, then flywheels a local model and counts errors.
module prbs5_checker #(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   prbs5_checker_if.slave  bus
);
   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(LOSS_CNT + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
   localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);

   state_t           state_q, state_d;
   logic [4:0]       hist_q, hist_d;
   logic [2:0]       seed_q, seed_d;
   logic [GW-1:0]    good_q, good_d, good_inc;
   logic [BW-1:0]    bad_q, bad_d, bad_inc;
   logic             locked_q, locked_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] bits_q, bits_d;
   logic             pred, miss;

   assign pred     = hist_q[4] ^ hist_q[1];
   assign miss     = bus.bit_in ^ pred;
   assign good_inc = good_q + 1'b1;
   assign bad_inc  = bad_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SEED;
         hist_q   <= '0;
         seed_q   <= '0;
         good_q   <= '0;
         bad_q    <= '0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         err_q    <= '0;
         bits_q   <= '0;
      end else begin
         state_q  <= state_d;
         hist_q   <= hist_d;
         seed_q   <= seed_d;
         good_q   <= good_d;
         bad_q    <= bad_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         err_q    <= err_d;
         bits_q   <= bits_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      seed_d  = seed_q;
      good_d  = good_q;
      bad_d   = bad_q;
      pulse_d = 1'b0;
      err_d   = err_q;
      bits_d  = bits_q;
      if (bus.bit_valid) begin
         case (state_q)
            SEED: begin
               hist_d = {hist_q[3:0], bus.bit_in};
               if (seed_q == 3'd4) begin
                  state_d = VERIFY;
                  seed_d  = '0;
                  good_d  = '0;
               end else begin
                  seed_d = seed_q + 1'b1;
               end
            end
            VERIFY: begin
               // Shift the received bit so a wrong seed washes out of hist.
               hist_d = {hist_q[3:0], bus.bit_in};
               good_d = miss ? '0 : good_inc;
               if (hist_d == 5'd0) begin
                  state_d = SEED;
                  seed_d  = '0;
                  good_d  = '0;
               end else if (!miss && good_inc == LOCK_V) begin
                  state_d = LOCKED;
                  bad_d   = '0;
               end
            end
            LOCKED: begin
               // Flywheel: the model feeds itself, so one flipped bit costs one error.
               hist_d = {hist_q[3:0], pred};
               if (bits_q != '1) bits_d = bits_q + 1'b1;
               if (miss) begin
                  pulse_d = 1'b1;
                  if (err_q != '1) err_d = err_q + 1'b1;
                  bad_d = bad_inc;
                  if (bad_inc == LOSS_V) begin
                     state_d = SEED;
                     seed_d  = '0;
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: begin
               state_d = SEED;
               seed_d  = '0;
            end
         endcase
      end
      if (bus.clr) begin
         err_d  = '0;
         bits_d = '0;
      end
      locked_d = (state_d == LOCKED);
   end

   assign bus.locked    = locked_q;
   assign bus.err_pulse = pulse_q;
   assign bus.err_count = err_q;
   assign bus.bit_count = bits_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_prbs5_checker.sv
// Directed bench for prbs5_checker: lock, single error, loss/relock, all-zero,
// gaps, clear, saturation (CNT_W=4 instance) and asynchronous reset.
module tb_prbs5_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clr = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_in = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   logic [0:0] exp_q[$];

   logic pat[31];
   int   pos = 0;

   prbs5_checker_if #(.CNT_W(16)) bus ();
   prbs5_checker_if #(.CNT_W(4))  bus_s ();

   assign bus.clr         = clr;
   assign bus.bit_valid   = bit_valid;
   assign bus.bit_in      = bit_in;
   assign bus_s.clr       = clr;
   assign bus_s.bit_valid = bit_valid;
   assign bus_s.bit_in    = bit_in;

   prbs5_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   prbs5_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic v, input logic b, input logic c);
      bit_valid = v;
      bit_in    = b;
      clr       = c;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("err_pulse_sb", {31'd0, bus.err_pulse}, {31'd0, exp_q.pop_front()});
   endtask

   task automatic send_pat(input logic flip, input logic c);
      logic b;
      b = pat[pos] ^ flip;
      pos = (pos == 30) ? 0 : pos + 1;
      send(1'b1, b, c);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      pos = 0;
   endtask

   initial begin
      int pulses, returns, vcnt;
      logic [1:0] prev_state;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
      for (int n = 5; n < 31; n++) pat[n] = pat[n-5] ^ pat[n-2];

      // reset values at start
      #1;
      check("rst_locked", {31'd0, bus.locked}, 32'd0);
      check("rst_pulse", {31'd0, bus.err_pulse}, 32'd0);
      check("rst_err", bus.err_count, 32'd0);
      check("rst_bits", bus.bit_count, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // clean lock: 13th valid bit locks
      for (int i = 0; i < 12; i++) send_pat(1'b0, 1'b0);
      check("lock_not_yet", {31'd0, bus.locked}, 32'd0);
      send_pat(1'b0, 1'b0);
      check("lock_13", {31'd0, bus.locked}, 32'd1);
      for (int i = 0; i < 310; i++) send_pat(1'b0, 1'b0);
      check("clean_err", bus.err_count, 32'd0);
      check("clean_bits", bus.bit_count, 32'd310);

      // single flipped bit: one pulse, flywheel keeps sync
      pulses = 0;
      exp_q.push_back(1'b1);
      send_pat(1'b1, 1'b0);
      check("single_err", bus.err_count, 32'd1);
      check("single_locked", {31'd0, bus.locked}, 32'd1);
      for (int i = 0; i < 40; i++) begin
         exp_q.push_back(1'b0);
         send_pat(1'b0, 1'b0);
         pulses += int'(bus.err_pulse);
      end
      check("single_no_more", pulses, 32'd0);
      check("single_err_after", bus.err_count, 32'd1);
      check("single_bits", bus.bit_count, 32'd351);

      // clear, then four consecutive errors lose lock
      send(1'b0, 1'b0, 1'b1);
      check("clr_err", bus.err_count, 32'd0);
      check("clr_bits", bus.bit_count, 32'd0);
      check("clr_keeps_lock", {31'd0, bus.locked}, 32'd1);
      for (int i = 0; i < 3; i++) send_pat(1'b1, 1'b0);
      check("loss_3_locked", {31'd0, bus.locked}, 32'd1);
      send_pat(1'b1, 1'b0);
      check("loss_4_unlocked", {31'd0, bus.locked}, 32'd0);
      check("loss_err", bus.err_count, 32'd4);
      check("loss_bits", bus.bit_count, 32'd4);
      for (int i = 0; i < 12; i++) send_pat(1'b0, 1'b0);
      check("relock_not_yet", {31'd0, bus.locked}, 32'd0);
      send_pat(1'b0, 1'b0);
      check("relock_13", {31'd0, bus.locked}, 32'd1);

      // all-zero input never locks and returns to SEED every 6th bit
      do_reset();
      returns = 0;
      pulses = 0;
      prev_state = bus.state;
      for (int i = 0; i < 100; i++) begin
         send(1'b1, 1'b0, 1'b0);
         pulses += int'(bus.locked);
         if (prev_state == 2'd1 && bus.state == 2'd0) returns++;
         prev_state = bus.state;
      end
      check("zero_never_locked", pulses, 32'd0);
      check("zero_seed_returns", returns, 32'd16);

      // gaps in bit_valid: lock point counted in valid bits
      do_reset();
      vcnt = 0;
      for (int cyc = 0; cyc < 200 && vcnt < 13; cyc++) begin
         if ($urandom_range(0, 1) == 1) begin
            send_pat(1'b0, 1'b0);
            vcnt++;
            if (vcnt == 12) check("gap_not_yet", {31'd0, bus.locked}, 32'd0);
            if (vcnt == 13) check("gap_lock_13", {31'd0, bus.locked}, 32'd1);
         end else begin
            send(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            check("gap_idle_pulse", {31'd0, bus.err_pulse}, 32'd0);
         end
      end
      check("gap_valid_count", vcnt, 32'd13);

      // clr coinciding with an error: counter 0, pulse still fires
      send_pat(1'b0, 1'b0);
      send_pat(1'b1, 1'b1);
      check("clr_err_pulse", {31'd0, bus.err_pulse}, 32'd1);
      check("clr_err_wins", bus.err_count, 32'd0);
      check("clr_bits_wins", bus.bit_count, 32'd0);
      send_pat(1'b0, 1'b0);
      check("post_clr_bits", bus.bit_count, 32'd1);
      check("post_clr_pulse", {31'd0, bus.err_pulse}, 32'd0);

      // saturation: 20 spaced errors
      send(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         send_pat(1'b1, 1'b0);
         send_pat(1'b0, 1'b0);
      end
      check("sat_err16", bus.err_count, 32'd20);
      check("sat_bits16", bus.bit_count, 32'd40);
      check("sat_err4", bus_s.err_count, 32'd15);
      check("sat_bits4", bus_s.bit_count, 32'd15);
      check("sat_locked", {31'd0, bus.locked}, 32'd1);

      // async reset mid-lock with a pulse in flight
      send_pat(1'b1, 1'b0);
      check("pre_rst_pulse", {31'd0, bus.err_pulse}, 32'd1);
      check("pre_rst_err", bus.err_count, 32'd21);
      #2 rst_n = 1'b0;
      #1;
      check("arst_locked", {31'd0, bus.locked}, 32'd0);
      check("arst_pulse", {31'd0, bus.err_pulse}, 32'd0);
      check("arst_err", bus.err_count, 32'd0);
      check("arst_bits", bus.bit_count, 32'd0);
      check("arst_state", {30'd0, bus.state}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
- Receive-side counterpart of the team's 5-bit LFSR pattern generator.
- Takes the generator's serial bit stream, one bit per valid cycle, with bit t equal to the generator's out[0] at cycle t.
- Self-synchronises to the stream, declares lock, then counts bit errors against a free-running local model.
- Used in loopback and link-test paths next to the generator.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions required in VERIFY before lock is declared.
- LOSS_CNT, 4: consecutive mismatches in LOCKED that force loss of lock.
- CNT_W, 16: width of err_count and bit_count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of err_count and bit_count; lock state is unaffected.
- bit_valid  input  1  bit_in is sampled this cycle.
- bit_in  input  1  received serial bit.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle pulse per error counted.
- err_count  output  CNT_W  saturating count of errors seen while locked.
- bit_count  output  CNT_W  saturating count of valid bits checked while locked.

Behaviour:
- Sequence rule: b[n] = b[n-5] XOR b[n-2]. Period is 31; a legal stream never contains 5 consecutive zeros.
- hist[4:0] holds the last 5 bits, hist[0] newest. Prediction pred = hist[4] XOR hist[1].
- Reset (async, rst_n=0):
  - state=SEED, hist=0, all internal counters 0.
  - locked=0, err_pulse=0, err_count=0, bit_count=0.
  - Reset asserted mid-lock aborts immediately to these values.
- All outputs are registered. Every event below appears on the outputs the cycle after the bit is sampled.
- Cycles with bit_valid=0 change no state, except that clr still applies and err_pulse returns to 0.
- SEED:
  - Each valid bit shifts bit_in into hist; seed_cnt increments.
  - On the 5th valid bit, go to VERIFY with good_cnt=0.
- VERIFY:
  - Each valid bit shifts bit_in (not pred) into hist, so the checker self-synchronises.
  - Match: good_cnt+1. When good_cnt reaches LOCK_CNT, go to LOCKED with bad_cnt=0.
  - Mismatch: good_cnt=0, stay in VERIFY.
  - If hist after the shift is all zeros: go to SEED with seed_cnt=0. The all-zero check takes priority over the lock transition.
  - err_count and bit_count do not change in VERIFY.
- LOCKED:
  - Each valid bit shifts pred (flywheel) into hist, so a single flipped bit gives exactly one error.
  - bit_count+1 (saturating at 2^CNT_W-1).
  - Match: bad_cnt=0.
  - Mismatch: err_pulse=1 next cycle, err_count+1 (saturating), bad_cnt+1.
  - When bad_cnt reaches LOSS_CNT: go to SEED with seed_cnt=0; locked=0 on the next cycle. The bit that causes loss of lock is still counted.
- clr:
  - Zeros err_count and bit_count. When clr coincides with a counted bit or error, clr wins and the counter reads 0.
  - err_pulse still fires.
- locked = (state==LOCKED), registered.
- Minimum lock latency from SEED: 5+LOCK_CNT valid bits. locked rises the cycle after the last of those bits.

Test Plan:
- Reset values: assert rst_n=0 mid-run with the generator seed 10101 stream flowing -> locked=0, err_pulse=0, err_count=0, bit_count=0 asynchronously, with no clock edge required.
- Clean lock:
  - Stimulus: continuous valid stream 1,0,1,0,1,1,1,0,1,1,… (generator seed 10101).
  - locked rises the cycle after the 13th valid bit.
  - After 310 further bits: err_count=0, bit_count=310.
- Single error:
  - Stimulus: while locked, invert one bit.
  - Exactly one err_pulse; err_count=1; locked stays 1.
  - Next bits produce no further errors.
- Loss and relock:
  - Stimulus: while locked, invert 4 consecutive bits.
  - err_count=4; locked falls the cycle after the 4th.
  - With a clean stream resuming, locked rises again after 13 valid bits.
- Illegal all-zero input: bit_in=0 held for 100 valid cycles -> locked never asserts; the checker returns to SEED each time hist becomes zero.
- Gaps and clear:
  - Stimulus: clean stream with bit_valid toggled 1/0 randomly -> same lock point counted in valid bits.
  - clr pulsed while an error is injected in the same cycle -> err_count=0, err_pulse=1.
  - err_count saturates at 2^CNT_W-1 when run with CNT_W=4 and 20 injected errors.
